// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register offsets within a channel,
// the channel stride and the bus-side FSM state encoding.
package gpio_pkg;

    localparam logic [4:0] OFS_OUT  = 5'h00;
    localparam logic [4:0] OFS_DIR  = 5'h04;
    localparam logic [4:0] OFS_IN   = 5'h08;
    localparam logic [4:0] OFS_PEND = 5'h0C;
    localparam logic [4:0] OFS_IE   = 5'h10;
    localparam logic [4:0] OFS_EDGE = 5'h14;

    localparam logic [31:0] CH_STRIDE = 32'h20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_t;

endpackage

// File: rtl/gpio_sync.sv
// Per-channel input path: multi-flop synchroniser followed by a history flop,
// producing the synchronised level and a per-bit rising/falling edge event.
module gpio_sync import gpio_pkg::*; #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] async_in,
    input  logic [WIDTH-1:0] edge_sel,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] edge_event
);

    logic [WIDTH-1:0] chain [SYNC_STAGES];
    logic [WIDTH-1:0] hist;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
            hist <= '0;
        end else begin
            chain[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            hist <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

    // edge_sel=1 selects falling edges for that bit, 0 selects rising edges
    assign edge_event = (edge_sel & ~sync_out & hist) | (~edge_sel & sync_out & ~hist);

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: NCH channels of OUT/DIR/IN/PEND/IE/EDGE registers
// behind a req/ready bus handshake with a registered interrupt output.
module gpio_ctrl import gpio_pkg::*; #(
    parameter int          NCH         = 2,
    parameter int          WIDTH       = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h8000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req,
    input  logic                 we,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic                 ready,
    output logic [31:0]          rdata,
    output logic                 err,
    input  logic [NCH*WIDTH-1:0] io_in,
    output logic [NCH*WIDTH-1:0] io_out,
    output logic [NCH*WIDTH-1:0] io_oe,
    output logic                 irq
);

    localparam int          CW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [31:0] WIN_SIZE = 32'(NCH) * CH_STRIDE;

    bus_state_t state, next_state;

    logic             we_q;
    logic [31:0]      addr_q;
    logic [WIDTH-1:0] wdata_q;

    logic [WIDTH-1:0] out_r  [NCH];
    logic [WIDTH-1:0] dir_r  [NCH];
    logic [WIDTH-1:0] pend_r [NCH];
    logic [WIDTH-1:0] ie_r   [NCH];
    logic [WIDTH-1:0] edge_r [NCH];

    logic [WIDTH-1:0] sync_val [NCH];
    logic [WIDTH-1:0] evt      [NCH];
    logic [WIDTH-1:0] pend_clr [NCH];

    logic [31:0]   offset;
    logic [31:0]   rd_val;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic          hit;
    logic          wr_en;
    logic [CW-1:0] acc_ch;
    logic [4:0]    acc_ofs;
    logic          irq_next;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        gpio_sync #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk        (clk),
            .rstn       (rstn),
            .async_in   (io_in[c*WIDTH +: WIDTH]),
            .edge_sel   (edge_r[c]),
            .sync_out   (sync_val[c]),
            .edge_event (evt[c])
        );
        assign io_out[c*WIDTH +: WIDTH] = out_r[c];
        assign io_oe[c*WIDTH +: WIDTH]  = dir_r[c];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            ST_IDLE:   if (req) next_state = ST_ACCESS;
            ST_ACCESS: next_state = ST_RESP;
            ST_RESP: begin
                ready      = 1'b1;
                next_state = ST_IDLE;
            end
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == ST_IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata[WIDTH-1:0];
        end
    end

    // Decode of the latched request; misaligned or out-of-window accesses never hit
    always_comb begin
        offset  = addr_q - BASE_ADDR;
        hit     = (addr_q >= BASE_ADDR) && (offset < WIN_SIZE) && (addr_q[1:0] == 2'b00);
        acc_ch  = offset[5 +: CW];
        acc_ofs = offset[4:0];
        wr_en   = (state == ST_ACCESS) && we_q && hit;
        rd_val  = '0;
        if (hit) begin
            case (acc_ofs)
                OFS_OUT:  rd_val[WIDTH-1:0] = out_r[acc_ch];
                OFS_DIR:  rd_val[WIDTH-1:0] = dir_r[acc_ch];
                OFS_IN:   rd_val[WIDTH-1:0] = sync_val[acc_ch];
                OFS_PEND: rd_val[WIDTH-1:0] = pend_r[acc_ch];
                OFS_IE:   rd_val[WIDTH-1:0] = ie_r[acc_ch];
                OFS_EDGE: rd_val[WIDTH-1:0] = edge_r[acc_ch];
                default:  rd_val = '0;
            endcase
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            pend_clr[c] = (wr_en && acc_ch == CW'(c) && acc_ofs == OFS_PEND) ? wdata_q : '0;
        end
    end

    // Pending bits: clear is applied before set so a simultaneous event survives
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NCH; c++) begin
                out_r[c]  <= '0;
                dir_r[c]  <= '0;
                pend_r[c] <= '0;
                ie_r[c]   <= '0;
                edge_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (wr_en && acc_ch == CW'(c)) begin
                    case (acc_ofs)
                        OFS_OUT:  out_r[c]  <= wdata_q;
                        OFS_DIR:  dir_r[c]  <= wdata_q;
                        OFS_IE:   ie_r[c]   <= wdata_q;
                        OFS_EDGE: edge_r[c] <= wdata_q;
                        default:  ;
                    endcase
                end
                pend_r[c] <= (pend_r[c] & ~pend_clr[c]) | evt[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state == ST_ACCESS) begin
            rdata_q <= (hit && !we_q) ? rd_val : '0;
            err_q   <= !hit;
        end
    end

    assign rdata = ready ? rdata_q : '0;
    assign err   = ready & err_q;

    always_comb begin
        irq_next = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            irq_next = irq_next | (|(pend_r[c] & ie_r[c]));
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_next;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: register-access vector table plus hand-timed
// sequences for interrupt latency, set-wins-over-clear, back-to-back reads and reset.
module tb_gpio_ctrl;

    localparam int          NCH         = 2;
    localparam int          WIDTH       = 32;
    localparam int          SYNC_STAGES = 2;
    localparam logic [31:0] BASE        = 32'h8000;
    localparam int          NVEC        = 20;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic [63:0] io_in;
    logic [63:0] io_out;
    logic [63:0] io_oe;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [NVEC];

    logic [31:0] rd, d1, d2;
    logic        e;
    int          lat, cnt, pulses, t1, t2;

    always #5 clk = ~clk;

    gpio_ctrl #(
        .NCH         (NCH),
        .WIDTH       (WIDTH),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .rdata  (rdata),
        .err    (err),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oe  (io_oe),
        .irq    (irq)
    );

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One bus transaction starting at a negedge; returns at a negedge with the FSM idle again
    task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rd_o, output logic e_o, output int lat_o);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        lat_o = 0;
        do begin
            @(posedge clk);
            lat_o++;
            @(negedge clk);
        end while (ready !== 1'b1 && lat_o < 20);
        check_output("ready_seen", {63'd0, ready}, 64'd1);
        rd_o = rdata;
        e_o  = err;
        req  = 1'b0;
        we   = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic        ee;
        int          l;
        apply_stimulus(1'b1, a, d, r, ee, l);
        check_output($sformatf("write 0x%0h err", a), {63'd0, ee}, 64'd0);
    endtask

    task automatic do_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        ee;
        int          l;
        apply_stimulus(1'b0, a, 32'h0, r, ee, l);
        check_output(name, {32'd0, r}, {32'd0, exp});
        check_output({name, " err"}, {63'd0, ee}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h8020, 32'hA5A5_0F0F, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 32'h8024, 32'hFFFF_0000, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 32'h8020, 32'h0, 32'hA5A5_0F0F, 1'b0};
        vecs[3]  = '{1'b0, 32'h8024, 32'h0, 32'hFFFF_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h8004, 32'h0, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 32'h8028, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h8028, 32'h0, 32'h0, 1'b0};
        vecs[7]  = '{1'b1, 32'h8018, 32'h1234_5678, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 32'h8018, 32'h0, 32'h0, 1'b0};
        vecs[9]  = '{1'b0, 32'h8040, 32'h0, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 32'h8002, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b1, 32'h8040, 32'hDEAD_BEEF, 32'h0, 1'b1};
        vecs[12] = '{1'b1, 32'h7FFC, 32'h1111_1111, 32'h0, 1'b1};
        vecs[13] = '{1'b1, 32'h8022, 32'h0, 32'h0, 1'b1};
        vecs[14] = '{1'b0, 32'h8020, 32'h0, 32'hA5A5_0F0F, 1'b0};
        vecs[15] = '{1'b1, 32'h8030, 32'h0000_FFFF, 32'h0, 1'b0};
        vecs[16] = '{1'b0, 32'h8030, 32'h0, 32'h0000_FFFF, 1'b0};
        vecs[17] = '{1'b1, 32'h8034, 32'h0000_0005, 32'h0, 1'b0};
        vecs[18] = '{1'b0, 32'h8034, 32'h0, 32'h0000_0005, 1'b0};
        vecs[19] = '{1'b0, 32'h803C, 32'h0, 32'h0, 1'b0};

        rstn  = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        io_in = '0;
        repeat (3) @(negedge clk);
        check_output("reset io_out", io_out, 64'd0);
        check_output("reset io_oe", io_oe, 64'd0);
        check_output("reset ready", {63'd0, ready}, 64'd0);
        check_output("reset rdata", {32'd0, rdata}, 64'd0);
        check_output("reset err", {63'd0, err}, 64'd0);
        check_output("reset irq", {63'd0, irq}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, e, lat);
            check_output($sformatf("vec%0d rdata", i), {32'd0, rd}, {32'd0, vecs[i].exp_rdata});
            check_output($sformatf("vec%0d err", i), {63'd0, e}, {63'd0, vecs[i].exp_err});
            check_output($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
        end
        check_output("io_out ch1", {32'd0, io_out[63:32]}, 64'hA5A5_0F0F);
        check_output("io_oe ch1", {32'd0, io_oe[63:32]}, 64'hFFFF_0000);
        check_output("io_out ch0", {32'd0, io_out[31:0]}, 64'd0);
        check_output("io_oe ch0", {32'd0, io_oe[31:0]}, 64'd0);

        // Rising-edge interrupt on channel 0 bit 0 and its latency
        do_write(BASE + 32'h10, 32'h9);
        do_write(BASE + 32'h14, 32'h0);
        check_output("irq idle", {63'd0, irq}, 64'd0);
        io_in[0] = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end while (irq !== 1'b1 && cnt < 20);
        check_output("irq latency", 64'(cnt), 64'(SYNC_STAGES + 2));
        do_read("pend0 after rise", BASE + 32'h0C, 32'h1);
        do_write(BASE + 32'h0C, 32'h1);
        check_output("irq after w1c", {63'd0, irq}, 64'd0);
        do_read("pend0 after w1c", BASE + 32'h0C, 32'h0);
        io_in[0] = 1'b0;
        repeat (6) @(negedge clk);
        do_read("pend0 after fall", BASE + 32'h0C, 32'h0);
        check_output("irq after fall", {63'd0, irq}, 64'd0);

        // Falling-edge selection on bit 1, masked by IE
        do_write(BASE + 32'h14, 32'h2);
        io_in[1] = 1'b1;
        repeat (6) @(negedge clk);
        do_read("pend0 falling sel ignores rise", BASE + 32'h0C, 32'h0);
        io_in[1] = 1'b0;
        repeat (6) @(negedge clk);
        do_read("pend0 falling sel", BASE + 32'h0C, 32'h2);
        check_output("irq masked by ie", {63'd0, irq}, 64'd0);
        do_write(BASE + 32'h0C, 32'h2);
        do_read("pend0 bit1 cleared", BASE + 32'h0C, 32'h0);

        // Event on bit 3 lands in the same cycle as a w1c of bit 3
        io_in[3] = 1'b1;
        @(negedge clk);
        apply_stimulus(1'b1, BASE + 32'h0C, 32'h8, rd, e, lat);
        check_output("set-wins write err", {63'd0, e}, 64'd0);
        do_read("pend0 set wins", BASE + 32'h0C, 32'h8);
        check_output("irq from bit3", {63'd0, irq}, 64'd1);

        // Back-to-back reads of IN0 with req held high
        io_in[31:0] = 32'h1234_5678;
        repeat (4) @(negedge clk);
        req    = 1'b1;
        we     = 1'b0;
        addr   = BASE + 32'h08;
        pulses = 0;
        t1 = 0; t2 = 0; d1 = '0; d2 = '0;
        for (int cyc = 1; cyc <= 20 && pulses < 2; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (ready === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    t1 = cyc;
                    d1 = rdata;
                end else begin
                    t2 = cyc;
                    d2 = rdata;
                    req = 1'b0;
                end
            end
        end
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("b2b pulse count", 64'(pulses), 64'd2);
        check_output("b2b first latency", 64'(t1), 64'd2);
        check_output("b2b spacing", 64'(t2 - t1), 64'd3);
        check_output("b2b rdata1", {32'd0, d1}, 64'h1234_5678);
        check_output("b2b rdata2", {32'd0, d2}, 64'h1234_5678);
        check_output("irq before reset", {63'd0, irq}, 64'd1);

        // Asynchronous reset in the middle of a write to OUT0
        req   = 1'b1;
        we    = 1'b1;
        addr  = BASE;
        wdata = 32'h0000_FFFF;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check_output("midreset io_out", io_out, 64'd0);
        check_output("midreset io_oe", io_oe, 64'd0);
        check_output("midreset ready", {63'd0, ready}, 64'd0);
        check_output("midreset rdata", {32'd0, rdata}, 64'd0);
        check_output("midreset err", {63'd0, err}, 64'd0);
        check_output("midreset irq", {63'd0, irq}, 64'd0);
        @(negedge clk);
        req  = 1'b0;
        we   = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        do_read("dir0 after reset", BASE + 32'h04, 32'h0);
        do_read("dir1 after reset", BASE + 32'h24, 32'h0);
        do_read("out0 no partial write", BASE, 32'h0);
        check_output("io_out after reset", io_out, 64'd0);
        check_output("irq after reset", {63'd0, irq}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
